// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_AUTH,
    GATE_IN,
    GATE_OUT
  } state_t;

  typedef enum logic {
    ENTRY,
    EXIT
  } lane_t;

  localparam int unsigned DEF_CAPACITY     = 20;
  localparam int unsigned DEF_OPEN_CYCLES  = 10;
  localparam int unsigned DEF_AUTH_TIMEOUT = 10;
  localparam int unsigned TIMER_W          = 8;

endpackage

// File: rtl/gate_timer.sv
// 8-bit down-counter shared by the auth window and the gate-open window.
module gate_timer
  import parking_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  // A window of N cycles is loaded with N; the final cycle reads 1.
  // A zero load expires at once so a zero-length window cannot stall the FSM.
  assign expire = (count <= TIMER_W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: round-robin entry/exit arbitration, auth wait, gate window, occupancy.
// Optional deny statistics counter enabled by macro PARKING_DENY_STATS_EN.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY     = DEF_CAPACITY,
  parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int unsigned AUTH_TIMEOUT = DEF_AUTH_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic        auth_ok,
  input  logic        auth_fail,
  input  logic        car_passed,
  output logic        entry_grant,
  output logic        gate_open,
  output logic        green_led,
  output logic        red_led,
  output logic [7:0]  occupancy,
  output logic        full,
  output logic        empty
`ifdef PARKING_DENY_STATS_EN
  ,
  output logic [15:0] deny_count
`endif
);

  localparam logic [7:0]         CAP_V  = 8'(CAPACITY);
  localparam logic [TIMER_W-1:0] OPEN_V = TIMER_W'(OPEN_CYCLES);
  localparam logic [TIMER_W-1:0] AUTH_V = TIMER_W'(AUTH_TIMEOUT);

  state_t             state, state_next;
  lane_t              last_served, served_next;
  logic [7:0]         occ_next;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               expire;
  logic               ent_cand, ex_cand;

  gate_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  assign ent_cand = entry_req && !full;
  assign ex_cand  = exit_req && !empty;

  always_comb begin
    state_next  = state;
    served_next = last_served;
    occ_next    = occupancy;
    timer_load  = 1'b0;
    timer_val   = '0;
    unique case (state)
      IDLE: begin
        // On conflict the lane not served last wins.
        if (ent_cand && (!ex_cand || last_served == EXIT)) begin
          state_next  = WAIT_AUTH;
          served_next = ENTRY;
          timer_load  = 1'b1;
          timer_val   = AUTH_V;
        end else if (ex_cand) begin
          state_next  = GATE_OUT;
          served_next = EXIT;
          timer_load  = 1'b1;
          timer_val   = OPEN_V;
        end
      end
      WAIT_AUTH: begin
        if (auth_ok) begin
          state_next = GATE_IN;
          timer_load = 1'b1;
          timer_val  = OPEN_V;
        end else if (auth_fail || expire) begin
          state_next = IDLE;
        end
      end
      GATE_IN: begin
        if (car_passed) begin
          state_next = IDLE;
          if (occupancy < CAP_V) occ_next = occupancy + 8'd1;
        end else if (expire) begin
          state_next = IDLE;
        end
      end
      GATE_OUT: begin
        if (car_passed) begin
          state_next = IDLE;
          if (occupancy != 8'd0) occ_next = occupancy - 8'd1;
        end else if (expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they change on the entering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= ENTRY;
      occupancy   <= '0;
      entry_grant <= 1'b0;
      gate_open   <= 1'b0;
      green_led   <= 1'b0;
      red_led     <= 1'b1;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      state       <= state_next;
      last_served <= served_next;
      occupancy   <= occ_next;
      entry_grant <= (state_next == WAIT_AUTH);
      gate_open   <= (state_next == GATE_IN) || (state_next == GATE_OUT);
      green_led   <= (state_next == GATE_IN) || (state_next == GATE_OUT);
      red_led     <= !((state_next == GATE_IN) || (state_next == GATE_OUT));
      full        <= (occ_next == CAP_V);
      empty       <= (occ_next == 8'd0);
    end
  end

`ifdef PARKING_DENY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      deny_count <= '0;
    end else if (state == WAIT_AUTH && !auth_ok && (auth_fail || expire)
                 && deny_count != 16'hFFFF) begin
      deny_count <= deny_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (default parameters).
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst, entry_req, exit_req, auth_ok, auth_fail, car_passed;
  logic       entry_grant, gate_open, green_led, red_led, full, empty;
  logic [7:0] occupancy;
`ifdef PARKING_DENY_STATS_EN
  logic [15:0] deny_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_deny = 0;

  parking_gate_arbiter #(
    .CAPACITY     (20),
    .OPEN_CYCLES  (10),
    .AUTH_TIMEOUT (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .auth_ok     (auth_ok),
    .auth_fail   (auth_fail),
    .car_passed  (car_passed),
    .entry_grant (entry_grant),
    .gate_open   (gate_open),
    .green_led   (green_led),
    .red_led     (red_led),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty)
`ifdef PARKING_DENY_STATS_EN
    ,
    .deny_count  (deny_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_deny(input string tag);
`ifdef PARKING_DENY_STATS_EN
    check(tag, 32'(deny_count), 32'(exp_deny));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_deny = 0;
  endtask

  task automatic do_entry();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    auth_ok = 1'b1;
    tick();
    auth_ok = 1'b0;
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    auth_ok = 1'b0; auth_fail = 1'b0; car_passed = 1'b0;

    // Reset state
    do_reset();
    check("rst_occ", 32'(occupancy), 0);
    check("rst_gate", 32'(gate_open), 0);
    check("rst_grant", 32'(entry_grant), 0);
    check("rst_red", 32'(red_led), 1);
    check("rst_green", 32'(green_led), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check_deny("rst_deny");

    // Basic entry: auth after 3 cycles, pass in second open cycle
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("ent_grant", 32'(entry_grant), 1);
    check("ent_gate0", 32'(gate_open), 0);
    tick();
    tick();
    check("ent_grant3", 32'(entry_grant), 1);
    auth_ok = 1'b1;
    tick();
    auth_ok = 1'b0;
    check("ent_open1", 32'(gate_open), 1);
    check("ent_green", 32'(green_led), 1);
    check("ent_grant_off", 32'(entry_grant), 0);
    tick();
    check("ent_open2", 32'(gate_open), 1);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("ent_closed", 32'(gate_open), 0);
    check("ent_red", 32'(red_led), 1);
    check("ent_occ", 32'(occupancy), 1);
    check("ent_empty", 32'(empty), 0);

    // Ignored pulses in IDLE
    car_passed = 1'b1;
    auth_ok = 1'b1;
    tick();
    car_passed = 1'b0;
    auth_ok = 1'b0;
    check("idle_ign_occ", 32'(occupancy), 1);
    check("idle_ign_gate", 32'(gate_open), 0);

    // Conflict after reset with occupancy 5: exit first, then entry
    do_reset();
    for (int i = 0; i < 5; i++) do_entry();
    check("conf_occ5", 32'(occupancy), 5);
    entry_req = 1'b1;
    exit_req = 1'b1;
    tick();
    check("conf1_gate", 32'(gate_open), 1);
    check("conf1_grant", 32'(entry_grant), 0);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("conf_idle_gate", 32'(gate_open), 0);
    check("conf_idle_grant", 32'(entry_grant), 0);
    check("conf_occ4", 32'(occupancy), 4);
    tick();
    entry_req = 1'b0;
    exit_req = 1'b0;
    check("conf2_grant", 32'(entry_grant), 1);
    check("conf2_gate", 32'(gate_open), 0);
    auth_fail = 1'b1;
    tick();
    auth_fail = 1'b0;
    exp_deny++;
    check("fail_idle", 32'(entry_grant), 0);
    check("fail_gate", 32'(gate_open), 0);
    check_deny("fail_deny");

    // Auth timeout
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("ato_last", 32'(entry_grant), 1);
    tick();
    exp_deny++;
    check("ato_idle", 32'(entry_grant), 0);
    check("ato_gate", 32'(gate_open), 0);
    check_deny("ato_deny");

    // Open-window timeout, occupancy unchanged
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    check("oto_open", 32'(gate_open), 1);
    for (int i = 0; i < 9; i++) tick();
    check("oto_last", 32'(gate_open), 1);
    tick();
    check("oto_closed", 32'(gate_open), 0);
    check("oto_occ", 32'(occupancy), 4);

    // car_passed on the expiry cycle counts
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("exp_last", 32'(gate_open), 1);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("exp_closed", 32'(gate_open), 0);
    check("exp_occ", 32'(occupancy), 3);

    // auth_ok and auth_fail together: ok wins
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    auth_ok = 1'b1;
    auth_fail = 1'b1;
    tick();
    auth_ok = 1'b0;
    auth_fail = 1'b0;
    check("both_open", 32'(gate_open), 1);
    check("both_grant", 32'(entry_grant), 0);
    check_deny("both_deny");
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("both_occ", 32'(occupancy), 4);
    tick();

    // Reset during GATE_IN with occupancy 7
    for (int i = 0; i < 3; i++) do_entry();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    auth_ok = 1'b1;
    tick();
    auth_ok = 1'b0;
    check("mid_open", 32'(gate_open), 1);
    check("mid_occ7", 32'(occupancy), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_deny = 0;
    check("mid_gate", 32'(gate_open), 0);
    check("mid_occ0", 32'(occupancy), 0);
    check("mid_empty", 32'(empty), 1);
    check("mid_red", 32'(red_led), 1);
    check_deny("mid_deny");

    // Full lot: entry refused, exit still served
    for (int i = 0; i < 20; i++) do_entry();
    check("full_occ", 32'(occupancy), 20);
    check("full_flag", 32'(full), 1);
    entry_req = 1'b1;
    tick();
    check("full_nogrant", 32'(entry_grant), 0);
    check("full_red", 32'(red_led), 1);
    exit_req = 1'b1;
    tick();
    check("full_exit_open", 32'(gate_open), 1);
    check("full_exit_grant", 32'(entry_grant), 0);
    entry_req = 1'b0;
    exit_req = 1'b0;
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("full_exit_occ", 32'(occupancy), 19);
    check("full_clear", 32'(full), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
